// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg
// Shared definitions for the instruction fetch controller:
//   RESET_PC_DEFAULT  default first fetch address after reset
//   WORD_INC          byte increment between sequential instructions
//   fetch_state_e     controller state encoding (FETCH / HOLD)
//   word_align()      clears the byte-offset bits of an address
package fetch_ctrl_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] WORD_INC         = 32'd4;

  // FETCH: a read request is outstanding at the current PC.
  // HOLD:  an instruction is buffered and waiting to be accepted.
  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_e;

  // Redirect targets may carry junk in the low two bits; masking keeps
  // every fetch address word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// fetch_pc_reg
// 32-bit program counter register with synchronous reset, parallel load
// and word increment. Load has priority over increment.
// Ports:
//   clk_i       clock, all updates on rising edge
//   reset_i     synchronous active-high reset, PC <= RESET_VAL
//   load_i      load load_val_i into the PC
//   load_val_i  value to load
//   incr_i      advance the PC by one word (wraps modulo 2^32)
//   pc_o        current PC
module fetch_pc_reg
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_VAL = RESET_PC_DEFAULT
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        load_i,
  input  logic [31:0] load_val_i,
  input  logic        incr_i,
  output logic [31:0] pc_o
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;

  // Next PC: a load (redirect) wins over a sequential increment; with
  // neither requested the PC simply holds.
  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_val_i;
    end else if (incr_i) begin
      pc_d = pc_q + WORD_INC;
    end
  end

  // PC state register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pc_q <= RESET_VAL;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl
// Single-entry instruction fetch controller. Requests one instruction at a
// time from instruction memory, buffers it for the IF/ID stage and follows
// redirect requests, including redirects that arrive while a read is still
// outstanding (these are parked in a pending register until the ack).
// Ports:
//   clk          clock, all state updates on rising edge
//   reset        synchronous active-high reset
//   stall        downstream cannot accept the buffered instruction
//   PCSrc        redirect request, target taken from NPC
//   NPC          redirect target (low two bits ignored)
//   im_req       instruction-memory read request
//   im_addr      word-aligned read address
//   im_ack       read data valid this cycle
//   im_rdata     read data
//   Instr_F_out  buffered instruction
//   PC4_F_out    buffered instruction address + 4
//   PC8_F_out    buffered instruction address + 8
//   valid_F_out  buffered instruction valid
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        PCSrc,
  input  logic [31:0] NPC,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ack,
  input  logic [31:0] im_rdata,
  output logic [31:0] Instr_F_out,
  output logic [31:0] PC4_F_out,
  output logic [31:0] PC8_F_out,
  output logic        valid_F_out
);

  fetch_state_e state_q, state_d;
  logic         pend_valid_q, pend_valid_d;
  logic [31:0]  pend_target_q, pend_target_d;
  logic [31:0]  instr_q, instr_d;

  logic         pc_load;
  logic [31:0]  pc_load_val;
  logic         pc_incr;
  logic [31:0]  pc;
  logic [31:0]  npc_aligned;

  assign npc_aligned = word_align(NPC);

  // The PC register doubles as the buffered-instruction address: it is not
  // touched between the ack and acceptance, so no separate copy is needed.
  fetch_pc_reg #(
    .RESET_VAL (RESET_PC)
  ) u_pc_reg (
    .clk_i      (clk),
    .reset_i    (reset),
    .load_i     (pc_load),
    .load_val_i (pc_load_val),
    .incr_i     (pc_incr),
    .pc_o       (pc)
  );

  // Next-state logic. In FETCH the request address must not move until the
  // ack, so a redirect arriving early is parked; at the ack, any redirect
  // (same-cycle first, then pending) turns the returned data into a discard
  // and retargets the PC. In HOLD a redirect beats acceptance and drops the
  // buffered instruction; im_ack is ignored there.
  always_comb begin
    state_d       = state_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    instr_d       = instr_q;
    pc_load       = 1'b0;
    pc_load_val   = pc;
    pc_incr       = 1'b0;

    unique case (state_q)
      FETCH: begin
        if (im_ack) begin
          if (PCSrc) begin
            pc_load      = 1'b1;
            pc_load_val  = npc_aligned;
            pend_valid_d = 1'b0;
          end else if (pend_valid_q) begin
            pc_load      = 1'b1;
            pc_load_val  = pend_target_q;
            pend_valid_d = 1'b0;
          end else begin
            instr_d = im_rdata;
            state_d = HOLD;
          end
        end else if (PCSrc) begin
          pend_valid_d  = 1'b1;
          pend_target_d = npc_aligned;
        end
      end

      HOLD: begin
        if (PCSrc) begin
          pc_load     = 1'b1;
          pc_load_val = npc_aligned;
          state_d     = FETCH;
        end else if (!stall) begin
          pc_incr = 1'b1;
          state_d = FETCH;
        end
      end

      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // Controller state, pending redirect and instruction buffer. Reset wins
  // over everything, so an ack landing on a reset edge is simply dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= FETCH;
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
      instr_q       <= '0;
    end else begin
      state_q       <= state_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
      instr_q       <= instr_d;
    end
  end

  assign im_req      = (state_q == FETCH);
  assign im_addr     = pc;
  assign valid_F_out = (state_q == HOLD);
  assign Instr_F_out = instr_q;
  assign PC4_F_out   = pc + WORD_INC;
  assign PC8_F_out   = pc + (WORD_INC << 1);

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_3000, the first fetch address after reset.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port stall  input  1  downstream (IF/ID) cannot accept this cycle.
REQ-005 SHALL have port PCSrc  input  1  redirect request, taken from NPC.
REQ-006 SHALL have port NPC  input  32  redirect target.
REQ-007 SHALL have port im_req  output  1  instruction-memory read request.
REQ-008 SHALL have port im_addr  output  32  read address, word-aligned.
REQ-009 SHALL have port im_ack  input  1  read data valid this cycle.
REQ-010 SHALL have port im_rdata  input  32  read data.
REQ-011 SHALL have port Instr_F_out  output  32  buffered instruction.
REQ-012 SHALL have port PC4_F_out  output  32  address of buffered instruction + 4.
REQ-013 SHALL have port PC8_F_out  output  32  address of buffered instruction + 8.
REQ-014 SHALL have port valid_F_out  output  1  buffered instruction valid.

Function
REQ-015 SHALL implement FSM states FETCH (request outstanding) and HOLD (instruction buffered).
REQ-016 In FETCH, im_req SHALL be 1 and im_addr SHALL equal the fetch PC; im_addr SHALL stay stable until im_ack.
REQ-017 In FETCH on im_ack with no redirect live: capture im_rdata and PC, go HOLD; valid_F_out = 1 from the next cycle.
REQ-018 In HOLD, im_req SHALL be 0; acceptance = valid_F_out & !stall.
REQ-019 On acceptance without redirect: PC <= PC+4 (mod 2^32, wrap from FFFF_FFFC to 0), go FETCH, valid_F_out = 0 next cycle.
REQ-020 Minimum throughput: one instruction per 2 cycles with im_ack in the request cycle.
REQ-021 PCSrc in HOLD SHALL discard the buffer (valid_F_out = 0 next cycle), PC <= {NPC[31:2],2'b00}, go FETCH; redirect beats acceptance.
REQ-022 PCSrc in FETCH without im_ack SHALL latch the target into a pending register; the current request continues unchanged.
REQ-023 On im_ack with a pending or same-cycle redirect: discard data, PC <= target, stay FETCH, clear pending; a same-cycle PCSrc overrides the pending target.
REQ-024 Repeated PCSrc while pending SHALL overwrite the pending target (last wins).
REQ-025 PC4_F_out/PC8_F_out SHALL be buffered PC +4/+8, 32-bit wrapping.
REQ-026 NPC[1:0] SHALL be ignored.
REQ-027 im_ack in HOLD SHALL be ignored.

Reset
REQ-028 With reset high at a clock edge: state FETCH, PC = RESET_PC, pending cleared, valid_F_out = 0, Instr_F_out = 0, PC4_F_out = RESET_PC+4, PC8_F_out = RESET_PC+8.
REQ-029 Reset SHALL override all inputs; im_ack coincident with reset SHALL be discarded; an abandoned request is not tracked.
REQ-030 First cycle after reset: im_req = 1, im_addr = RESET_PC.

Structure
REQ-031 A shared package SHALL hold RESET_PC default, state encodings, and word-increment constant 4.
REQ-032 One sub-module, fetch_pc_reg (32-bit PC register with load/increment/reset), SHALL be instantiated; FSM, pending register and buffer stay in fetch_ctrl.

Verification
REQ-033 Reset then im_ack every cycle, stall = 0 -> im_addr 3000, 3004, 3008 on alternating cycles; valid_F_out pulses with PC4_F_out 3004, 3008, 300C.
REQ-034 Buffer at 3000, stall held 3 cycles -> valid_F_out, Instr_F_out, PC4_F_out stable, im_req = 0; after release next im_addr = 3004.
REQ-035 PCSrc = 1, NPC = 3401 in HOLD with stall = 0 -> buffer dropped, next im_addr = 3400, no valid for 3000.
REQ-036 PCSrc, NPC = 4000 during FETCH of 3004, im_ack 3 cycles later -> im_addr held at 3004 until ack, data discarded, next im_addr = 4000.
REQ-037 Two redirects 4000 then 5000 while pending, ack later -> next im_addr = 5000; PC = FFFF_FFFC accepted -> next im_addr = 0.
REQ-038 Reset asserted during outstanding fetch with im_ack same cycle -> valid_F_out = 0, next im_addr = 3000.
